// File: rtl/piano_pkg.sv
// Shared definitions for the piano recorder and its playback engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package piano_pkg;

  // Key codes stored in a record and driven on play_key
  localparam logic [1:0] KEY_NONE = 2'b00;
  localparam logic [1:0] KEY_DO   = 2'b01;
  localparam logic [1:0] KEY_RE   = 2'b10;
  localparam logic [1:0] KEY_MI   = 2'b11;

  // Bit positions of the fields inside a 28-bit behaviour RAM word
  localparam int REC_KEY_HI   = 27;
  localparam int REC_KEY_LO   = 26;
  localparam int REC_START_HI = 25;
  localparam int REC_START_LO = 13;
  localparam int REC_DUR_HI   = 12;
  localparam int REC_DUR_LO   = 0;

  // 0.01 s at 50 MHz
  localparam int TICK_DIV_DEFAULT = 500000;

  // Largest representable playback time
  localparam logic [12:0] TIME_MAX = 13'h1FFF;

  typedef struct packed {
    logic [1:0]  key;
    logic [12:0] start;
    logic [12:0] dur;
  } note_rec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_HOLD,
    S_PLAY,
    S_DONE
  } state_t;

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: toggles speaker every half-period of the key.
// Latency: first rising edge HALF cycles after key changes; silent at once for key 00.
// Backpressure: none.
// Ports: clock, reset (sync, active-high), key[1:0] in; speaker out.
import piano_pkg::*;

module tone_gen #(
  parameter int DO_HALF = 95556,
  parameter int RE_HALF = 85131,
  parameter int MI_HALF = 75842
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] key,
  output logic       speaker
);

  localparam logic [18:0] DO_M1 = 19'(DO_HALF - 1);
  localparam logic [18:0] RE_M1 = 19'(RE_HALF - 1);
  localparam logic [18:0] MI_M1 = 19'(MI_HALF - 1);

  logic [1:0]  key_q;
  logic [18:0] cnt;
  logic [18:0] half_m1;
  logic        spk_q;

  always_comb begin
    half_m1 = '0;
    case (key)
      KEY_DO:  half_m1 = DO_M1;
      KEY_RE:  half_m1 = RE_M1;
      KEY_MI:  half_m1 = MI_M1;
      default: half_m1 = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_q <= KEY_NONE;
      cnt   <= '0;
      spk_q <= 1'b0;
    end else begin
      key_q <= key;
      if (key == KEY_NONE) begin
        cnt   <= '0;
        spk_q <= 1'b0;
      end else if (key != key_q) begin
        // The cycle the new key appears is already the first cycle of
        // its half-period, so the restarted count is one short.
        cnt   <= half_m1 - 19'd1;
        spk_q <= 1'b0;
      end else if (cnt == '0) begin
        cnt   <= half_m1;
        spk_q <= ~spk_q;
      end else begin
        cnt <= cnt - 19'd1;
      end
    end
  end

  // Gate with the live key so the tone stops in the same cycle play_key clears
  assign speaker = spk_q & (key != KEY_NONE);

endmodule

// File: rtl/note_player.sv
// Playback engine: fetches recorded notes from the behaviour RAM and replays them in time.
// Latency: 3 cycles per record fetch; note onset 1 cycle after play_time reaches its start.
// Backpressure: none; start ignored while busy, stop aborts to IDLE next cycle.
// Ports: clock, reset, start, stop, num_entries in; rd_addr out / rd_data in (1-cycle RAM);
//        play_time, play_key, speaker, busy, done out.
import piano_pkg::*;

module note_player #(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int DO_HALF  = 95556,
  parameter int RE_HALF  = 85131,
  parameter int MI_HALF  = 75842
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [12:0] num_entries,
  output logic [12:0] rd_addr,
  input  logic [27:0] rd_data,
  output logic [12:0] play_time,
  output logic [1:0]  play_key,
  output logic        speaker,
  output logic        busy,
  output logic        done
);

  localparam logic [18:0] TICK_RELOAD = 19'(TICK_DIV - 1);

  state_t      state, state_nxt;
  note_rec_t   rec;
  logic [12:0] n_reg, start_r, dur_r, elapsed, next_addr;
  logic [1:0]  key_r;
  logic [18:0] tick_cnt;
  logic        tick, last_rec, skip_rec, onset, play_end;

  always_comb begin
    rec       = '0;
    rec.key   = rd_data[REC_KEY_HI:REC_KEY_LO];
    rec.start = rd_data[REC_START_HI:REC_START_LO];
    rec.dur   = rd_data[REC_DUR_HI:REC_DUR_LO];
  end

  assign tick      = (state != S_IDLE) && (tick_cnt == '0);
  assign next_addr = rd_addr + 13'd1;
  assign last_rec  = (next_addr == n_reg);
  // Release markers and zero-length notes carry nothing to play
  assign skip_rec  = (rec.key == KEY_NONE) || (rec.dur == '0);
  assign onset     = (state == S_HOLD) && (play_time >= start_r);
  assign play_end  = (state == S_PLAY) && (elapsed == dur_r);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_entries == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_LOAD;
      S_LOAD: begin
        if (skip_rec) state_nxt = last_rec ? S_DONE : S_FETCH;
        else          state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (play_time >= start_r)      state_nxt = S_PLAY;
        else if (play_time == TIME_MAX) state_nxt = S_DONE;
      end
      S_PLAY:  if (play_end) state_nxt = last_rec ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // stop overrides everything, including a start in the same cycle
    if (stop) state_nxt = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      n_reg     <= '0;
      rd_addr   <= '0;
      play_time <= '0;
      tick_cnt  <= '0;
      key_r     <= KEY_NONE;
      start_r   <= '0;
      dur_r     <= '0;
      elapsed   <= '0;
      play_key  <= KEY_NONE;
    end else begin
      if (state == S_IDLE) begin
        if (start && !stop) begin
          n_reg     <= num_entries;
          rd_addr   <= '0;
          play_time <= '0;
          tick_cnt  <= '0;
        end
      end else begin
        tick_cnt <= tick ? TICK_RELOAD : tick_cnt - 19'd1;
        if (tick && (play_time != TIME_MAX)) play_time <= play_time + 13'd1;
      end

      if (state == S_LOAD) begin
        key_r   <= rec.key;
        start_r <= rec.start;
        dur_r   <= rec.dur;
      end

      if (((state == S_LOAD) && skip_rec) || play_end) rd_addr <= next_addr;

      if (onset) begin
        play_key <= key_r;
        elapsed  <= '0;
      end else if ((state == S_PLAY) && tick) begin
        elapsed <= elapsed + 13'd1;
      end

      if (play_end || stop) play_key <= KEY_NONE;
    end
  end

  tone_gen #(
    .DO_HALF(DO_HALF),
    .RE_HALF(RE_HALF),
    .MI_HALF(MI_HALF)
  ) u_tone (
    .clock  (clock),
    .reset  (reset),
    .key    (play_key),
    .speaker(speaker)
  );

endmodule

// File: tb/tb_note_player.sv
`timescale 1ns/1ps
module tb_note_player;

  localparam int T   = 4;
  localparam int DOH = 3;
  localparam int REH = 5;
  localparam int MIH = 7;

  logic        clock;
  logic        reset, start, stop;
  logic [12:0] num_entries, rd_addr, play_time;
  logic [27:0] rd_data;
  logic [1:0]  play_key;
  logic        speaker, busy, done;

  logic [27:0] mem [0:8191];

  typedef struct {
    bit is_done;
    int key;
    int start;
    int dur;
    int slack;
  } exp_t;

  exp_t sb[$];
  int   rk[16], rs[16], rdu[16];
  int   tests, fails, cyc, done_cnt, last_end_pt;
  bit   aborting, wrap_seen;

  note_player #(.TICK_DIV(T), .DO_HALF(DOH), .RE_HALF(REH), .MI_HALF(MIH)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .num_entries(num_entries), .rd_addr(rd_addr), .rd_data(rd_data),
    .play_time(play_time), .play_key(play_key), .speaker(speaker),
    .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) rd_data <= mem[rd_addr];

  function automatic int half_of(input int k);
    case (k)
      1: return DOH;
      2: return REH;
      3: return MIH;
      default: return 0;
    endcase
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_rec(input int i, input int k, input int s, input int d);
    rk[i] = k; rs[i] = s; rdu[i] = d;
    mem[i] = {2'(k), 13'(s), 13'(d)};
  endtask

  // Reference: playable records come out in address order, then one done.
  task automatic model(input int n);
    int skips;
    skips = 0;
    for (int i = 0; i < n; i++) begin
      if (rk[i] == 0 || rdu[i] == 0) skips++;
      else begin
        sb.push_back('{1'b0, rk[i], rs[i], rdu[i], skips});
        skips = 0;
      end
    end
    sb.push_back('{1'b1, 0, 0, 0, 0});
  endtask

  task automatic monitor();
    int   pk, ppt, on_cyc, edge_cyc, lim, len;
    bit   pspk, pbusy, cur_valid;
    exp_t e, cur;
    pk = 0; ppt = 0; on_cyc = 0; edge_cyc = 0; pspk = 0; pbusy = 0; cur_valid = 0;
    cur = '{1'b0, 0, 0, 0, 0};
    forever begin
      @(negedge clock);
      cyc++;
      if (busy && !pbusy) last_end_pt = 0;
      if (busy && pbusy && (int'(play_time) < ppt)) wrap_seen = 1;
      if (pk == 0 && play_key != 0) begin
        on_cyc = cyc; edge_cyc = cyc;
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_note", int'(play_key), 0);
          cur_valid = 0;
        end else begin
          e = sb.pop_front(); cur = e; cur_valid = 1;
          check(!e.is_done && e.key == int'(play_key), "note_key", int'(play_key), e.is_done ? -1 : e.key);
          check(int'(play_time) >= e.start, "onset_early", int'(play_time), e.start);
          lim = imax(e.start, last_end_pt) + 2 + e.slack;
          check(int'(play_time) <= lim, "onset_late", int'(play_time), lim);
        end
      end else if (pk != 0 && play_key == 0) begin
        if (!aborting && cur_valid && !cur.is_done) begin
          len = cyc - on_cyc;
          check(len >= (cur.dur - 1) * T + 2 && len <= cur.dur * T + 1, "note_len", len, cur.dur * T);
        end
        last_end_pt = int'(play_time);
        cur_valid = 0;
      end
      if (play_key != 0 && pk == int'(play_key) && speaker != pspk) begin
        check(cyc - edge_cyc == half_of(int'(play_key)), "tone_half", cyc - edge_cyc, half_of(int'(play_key)));
        edge_cyc = cyc;
      end
      if (play_key == 0 && speaker) check(1'b0, "speaker_silent", 1, 0);
      if (done) begin
        if (sb.size() == 0) check(1'b0, "unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          check(e.is_done, "done_order", 1, int'(e.is_done));
        end
        done_cnt++;
      end
      pk = int'(play_key); pspk = speaker; pbusy = busy; ppt = int'(play_time);
    end
  endtask

  // Start a run of n records and wait (bounded) for its single done pulse.
  task automatic play(input int n, input int budget, input bit restart, output int waited);
    int d0, c;
    d0 = done_cnt;
    @(negedge clock); #1;
    start = 1'b1; num_entries = 13'(n);
    @(negedge clock); #1;
    start = 1'b0;
    check(busy == 1'b1, "busy_rise", int'(busy), 1);
    c = 0;
    while (done_cnt == d0 && c < budget) begin
      start = (restart && c == 6);
      num_entries = '0;
      @(negedge clock); #1;
      c++;
    end
    start = 1'b0;
    waited = c;
    check(done_cnt == d0 + 1, "done_pulse", done_cnt - d0, 1);
    @(negedge clock); #1;
    check(busy == 1'b0, "busy_fall", int'(busy), 0);
    check(done_cnt == d0 + 1, "done_once", done_cnt - d0, 1);
    check(sb.size() == 0, "sb_empty", sb.size(), 0);
  endtask

  task automatic abort_run(input bit use_reset);
    int d0, c;
    d0 = done_cnt;
    aborting = 1'b1;
    set_rec(0, 1, 0, 8);
    sb.push_back('{1'b0, 1, 0, 8, 0});
    @(negedge clock); #1;
    start = 1'b1; num_entries = 13'd1;
    @(negedge clock); #1;
    start = 1'b0;
    c = 0;
    while (play_key != 2'b01 && c < 50) begin @(negedge clock); #1; c++; end
    check(play_key == 2'b01, "abort_reach_play", int'(play_key), 1);
    repeat (4) begin @(negedge clock); #1; end
    if (use_reset) reset = 1'b1; else stop = 1'b1;
    @(negedge clock); #1;
    reset = 1'b0; stop = 1'b0;
    check(play_key == 2'b00, use_reset ? "rst_key" : "stop_key", int'(play_key), 0);
    check(speaker == 1'b0, use_reset ? "rst_spk" : "stop_spk", int'(speaker), 0);
    check(busy == 1'b0, use_reset ? "rst_busy" : "stop_busy", int'(busy), 0);
    if (use_reset) check(play_time == 13'd0, "rst_time", int'(play_time), 0);
    repeat (10) begin @(negedge clock); #1; end
    check(done_cnt == d0, use_reset ? "rst_no_done" : "stop_no_done", done_cnt - d0, 0);
    check(sb.size() == 0, "abort_sb", sb.size(), 0);
    aborting = 1'b0;
  endtask

  initial begin
    int w, n, t0;
    tests = 0; fails = 0; cyc = 0; done_cnt = 0; last_end_pt = 0;
    aborting = 1'b0; wrap_seen = 1'b0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; num_entries = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    fork monitor(); join_none
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock); #1;
    check(rd_addr == 13'd0, "rst_rd_addr", int'(rd_addr), 0);
    check(play_time == 13'd0, "rst_play_time", int'(play_time), 0);
    check(play_key == 2'b00, "rst_play_key", int'(play_key), 0);
    check(speaker == 1'b0, "rst_speaker", int'(speaker), 0);
    check(busy == 1'b0, "rst_busy0", int'(busy), 0);
    check(done == 1'b0, "rst_done", int'(done), 0);

    // Single note
    set_rec(0, 1, 3, 2);
    model(1); play(1, 500, 1'b0, w);

    // Skip release / zero-duration records
    set_rec(0, 0, 0, 5); set_rec(1, 2, 1, 0); set_rec(2, 3, 2, 1);
    model(3); play(3, 500, 1'b0, w);

    // Late start behind an overlapping note
    set_rec(0, 1, 0, 4); set_rec(1, 2, 2, 1);
    model(2); play(2, 500, 1'b0, w);

    // Empty run
    model(0); play(0, 5, 1'b0, w);
    check(w <= 1, "empty_latency", w, 1);

    // Random programs, first one also tries a start while busy
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(3, 6);
      t0 = 0;
      for (int i = 0; i < n; i++) begin
        t0 += $urandom_range(0, 6);
        set_rec(i, $urandom_range(0, 3), t0, $urandom_range(0, 4));
      end
      model(n); play(n, 3000, it == 0, w);
    end

    // stop and start together: stop wins
    @(negedge clock); #1;
    start = 1'b1; stop = 1'b1; num_entries = 13'd1;
    @(negedge clock); #1;
    start = 1'b0; stop = 1'b0;
    check(busy == 1'b0, "stop_beats_start", int'(busy), 0);

    abort_run(1'b0);
    abort_run(1'b1);

    // Saturation of the time base
    set_rec(0, 1, 8191, 3);
    model(1); play(1, 34000, 1'b0, w);
    check(play_time == 13'd8191, "sat_hold", int'(play_time), 8191);
    check(wrap_seen == 1'b0, "no_wrap", int'(wrap_seen), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
